// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder controller: feeds one 4-bit slice per cycle to an external ripple adder.
// Optional OVERFLOW_FLAG_EN adds a registered signed-overflow output ovf.
module nibble_serial_adder_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic                 cin,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] result,
   output logic                 cout,
`ifdef OVERFLOW_FLAG_EN
   output logic                 ovf,
`endif
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_c,
   input  logic [3:0]           add_sum,
   input  logic                 add_carry
);

   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned IW = $clog2(NIBBLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_next;
   logic [W-1:0]    lat_a, lat_b;
   logic            lat_cin;
   logic [IW-1:0]   idx;
   logic            carry;
   logic [IW+1:0]   base;
   logic            last;

   assign base = {idx, 2'b00};
   assign last = (idx == IW'(NIBBLES - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      add_a = '0;
      add_b = '0;
      add_c = 1'b0;
      case (state)
         RUN: begin
            busy  = 1'b1;
            add_a = lat_a[base +: 4];
            add_b = lat_b[base +: 4];
            add_c = (idx == '0) ? lat_cin : carry;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_a   <= '0;
         lat_b   <= '0;
         lat_cin <= 1'b0;
         idx     <= '0;
         carry   <= 1'b0;
         result  <= '0;
         cout    <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
         ovf     <= 1'b0;
`endif
      end else if (state != RUN) begin
         if (start) begin
            lat_a   <= op_a;
            lat_b   <= op_b;
            lat_cin <= cin;
            idx     <= '0;
         end
      end else begin
         result[base +: 4] <= add_sum;
         carry             <= add_carry;
         idx               <= idx + 1'b1;
         if (last) begin
            cout <= add_carry;
`ifdef OVERFLOW_FLAG_EN
            // Sum MSB comes straight from the adder; result is not yet updated.
            ovf  <= (lat_a[W-1] == lat_b[W-1]) && (add_sum[3] != lat_a[W-1]);
`endif
         end
      end
   end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous to clk and active-high.
REQ-004 Port: start  input  1  request to begin an addition.
REQ-005 Port: op_a  input  W  operand A.
REQ-006 Port: op_b  input  W  operand B.
REQ-007 Port: cin  input  1  carry-in for the operation.
REQ-008 Port: busy  output  1  high while slices are being processed.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: result  output  W  registered sum.
REQ-011 Port: cout  output  1  registered carry-out of the MSB slice.
REQ-012 Port: add_a  output  4  slice of A driven to the external 4-bit ripple carry adder.
REQ-013 Port: add_b  output  4  slice of B driven to the external adder.
REQ-014 Port: add_c  output  1  carry-in driven to the external adder.
REQ-015 Port: add_sum  input  4  sum returned combinationally by the external adder.
REQ-016 Port: add_carry  input  1  carry returned combinationally by the external adder.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-018 In IDLE or DONE, start=1 SHALL latch op_a, op_b and cin into internal registers, clear the slice index to 0, and enter RUN.
REQ-019 start SHALL be ignored while in RUN; latched operands SHALL not change until the next accepted start.
REQ-020 In RUN with slice index k, add_a and add_b SHALL be bits [4k+3:4k] of the latched operands; add_c SHALL be latched cin for k=0, else the registered add_carry from slice k-1.
REQ-021 On each RUN edge, add_sum SHALL be written to result[4k+3:4k], add_carry SHALL be registered, and k SHALL increment.
REQ-022 On the edge with k=NIBBLES-1, add_carry SHALL be written to cout and the FSM SHALL enter DONE.
REQ-023 Latency: start accepted in cycle T -> RUN for cycles T+1..T+NIBBLES -> done=1 exactly in cycle T+NIBBLES+1.
REQ-024 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-025 DONE SHALL last one cycle: next state is RUN if start=1, else IDLE.
REQ-026 result and cout SHALL hold their final values through DONE and IDLE until the next accepted start; during RUN, slices not yet written SHALL hold prior values.
REQ-027 In IDLE and DONE, add_a, add_b and add_c SHALL drive 0.
REQ-028 Arithmetic SHALL be unsigned modulo 2^W; {cout,result} SHALL equal op_a+op_b+cin.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, cout=0, slice index=0 and internal carry=0, with priority over start.
REQ-030 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL be produced for it.

Configuration
REQ-031 Macro OVERFLOW_FLAG_EN: when defined, output port ovf (1 bit) SHALL exist and be registered together with cout, equal to (a_msb==b_msb)&&(result_msb!=a_msb), reset to 0, and held like result.
REQ-032 Without OVERFLOW_FLAG_EN, the ovf port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-033 NIBBLES=4: op_a=0x1234, op_b=0x4321, cin=0, start pulse -> done in cycle T+5, result=0x5555, cout=0.
REQ-034 op_a=0xFFFF, op_b=0x0001, cin=0 -> result=0x0000, cout=1; add_c=1 for slices 1..3.
REQ-035 op_a=0x00FF, op_b=0x0000, cin=1 -> result=0x0100, cout=0.
REQ-036 start held high during RUN with different operands -> ignored; first result correct; back-to-back start in DONE -> second op begins in the next cycle.
REQ-037 rst asserted in cycle T+2 of an op -> next cycle IDLE, result=0, cout=0, no done pulse.
REQ-038 With OVERFLOW_FLAG_EN: op_a=0x7FFF, op_b=0x0001, cin=0 -> result=0x8000, ovf=1, cout=0.
